// File: rtl/spi_slave_regfile.sv
// SPI mode-3 responder fronting a 64 x 8 register file with one read-only identity register.
// All SPI pins are oversampled in the clk domain; the host side reads the file combinationally.
module spi_slave_regfile #(
    parameter logic [5:0] ID_ADDR  = 6'h0F,
    parameter logic [7:0] ID_VALUE = 8'h33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       miso_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [5:0] host_addr,
    output logic [7:0] host_rdata
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

    state_t     state_q, state_d;
    // [0],[1] form the synchroniser, [2] holds the previous synced value for edge detection
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] cmd_q, cmd_d;
    logic [6:0] data_q, data_d;
    logic [7:0] shreg_q, shreg_d;
    logic [5:0] addr_q, addr_d;
    logic       ms_q, ms_d;
    logic       miso_q, miso_d;
    logic       oe_q, oe_d;
    logic       strobe_q, strobe_d;
    logic [5:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] regs_q [64];

    logic       sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;
    logic [7:0] cmd_byte, data_byte;
    logic [5:0] addr_inc;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_high   = cs_q[1];
    assign mosi_s    = mosi_q[1];
    // Command arrives MSB first (rw, ms, addr[5:0]); data arrives LSB first
    assign cmd_byte  = {cmd_q, mosi_s};
    assign data_byte = {mosi_s, data_q};
    assign addr_inc  = addr_q + 6'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        shreg_d  = shreg_q;
        addr_d   = addr_q;
        ms_d     = ms_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    cnt_d   = 3'd0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 3'd1;
                    cmd_d = cmd_byte[6:0];
                    if (cnt_q == 3'd7) begin
                        ms_d    = cmd_byte[6];
                        addr_d  = cmd_byte[5:0];
                        shreg_d = regs_q[cmd_byte[5:0]];
                        state_d = cmd_byte[7] ? RDATA : WDATA;
                    end
                end
            end
            WDATA: begin
                if (sclk_rise) begin
                    cnt_d  = cnt_q + 3'd1;
                    data_d = {mosi_s, data_q[6:1]};
                    if (cnt_q == 3'd7) begin
                        if (addr_q != ID_ADDR) begin
                            strobe_d = 1'b1;
                            waddr_d  = addr_q;
                            wdata_d  = data_byte;
                        end
                        if (ms_q) begin
                            addr_d = addr_inc;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            RDATA: begin
                if (sclk_fall) begin
                    miso_d = shreg_q[cnt_q];
                    oe_d   = 1'b1;
                end
                if (sclk_rise) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (ms_q) begin
                            addr_d  = addr_inc;
                            shreg_d = regs_q[addr_inc];
                        end else begin
                            state_d = DONE;
                            miso_d  = 1'b0;
                            oe_d    = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Deselect wins over everything: a byte completing on the same clk is dropped
        if (state_q != IDLE && cs_high) begin
            state_d  = IDLE;
            miso_d   = 1'b0;
            oe_d     = 1'b0;
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q   <= 3'b111;
            cs_q     <= 3'b111;
            mosi_q   <= 2'b00;
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            cmd_q    <= 7'd0;
            data_q   <= 7'd0;
            shreg_q  <= 8'd0;
            addr_q   <= 6'd0;
            ms_q     <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            strobe_q <= 1'b0;
            waddr_q  <= 6'd0;
            wdata_q  <= 8'd0;
        end else begin
            sclk_q   <= {sclk_q[1:0], spi_clk};
            cs_q     <= {cs_q[1:0], spi_cs};
            mosi_q   <= {mosi_q[0], spi_mosi};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            data_q   <= data_d;
            shreg_q  <= shreg_d;
            addr_q   <= addr_d;
            ms_q     <= ms_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // The array commits on the same edge that raises wr_strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= (6'(i) == ID_ADDR) ? ID_VALUE : 8'h00;
            end
        end else if (strobe_d) begin
            regs_q[waddr_d] <= wdata_d;
        end
    end

    assign spi_miso   = miso_q;
    assign miso_oe    = oe_q;
    assign busy       = (state_q != IDLE);
    assign wr_strobe  = strobe_q;
    assign wr_addr    = waddr_q;
    assign wr_data    = wdata_q;
    assign host_rdata = regs_q[host_addr];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed and randomized SPI frames against spi_slave_regfile, checked with a register-array model.
module tb_spi_slave_regfile;

    localparam logic [5:0] ID_A = 6'h0F;
    localparam logic [7:0] ID_V = 8'h33;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk = 1'b1;
    logic       spi_cs = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, miso_oe, busy, wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] host_addr = 6'd0;
    logic [7:0] host_rdata;

    spi_slave_regfile dut (
        .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .miso_oe(miso_oe), .busy(busy), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .wr_data(wr_data), .host_addr(host_addr), .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          oe_err = 0;
    logic [7:0]  model [64];
    logic [7:0]  wq [$];
    logic [7:0]  rq [$];
    logic [7:0]  exp_rd [$];
    logic [13:0] exp_wr [$];
    logic [13:0] got_wr [$];

    always @(posedge clk) begin
        if (wr_strobe) got_wr.push_back({wr_addr, wr_data});
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        model[ID_A] = ID_V;
    endtask

    // One SPI bit: master drives mosi with clk low, samples miso just before raising clk
    task automatic clock_bit(input logic b, input bit in_data, input bit is_read, output logic smp);
        spi_clk  = 1'b0;
        spi_mosi = b;
        repeat (6) @(negedge clk);
        smp = spi_miso;
        if (in_data && is_read) begin
            if (miso_oe !== 1'b1) oe_err++;
        end else if (miso_oe !== 1'b0) begin
            oe_err++;
        end
        spi_clk = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame(input logic rw, input logic ms, input logic [5:0] addr,
                         input int nbytes, input int abort_at);
        logic [7:0] cmd, b, r;
        logic       s;
        bit         stop;
        cmd  = {rw, ms, addr};
        stop = 1'b0;
        rq.delete();
        oe_err = 0;
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) clock_bit(cmd[7-i], 1'b0, rw, s);
        for (int j = 0; j < nbytes; j++) begin
            b = rw ? 8'h00 : wq[j];
            r = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (abort_at >= 0 && j*8 + k >= abort_at) stop = 1'b1;
                if (!stop) begin
                    clock_bit(b[k], 1'b1, rw, s);
                    r[k] = s;
                end
            end
            if (!stop) rq.push_back(r);
        end
        repeat (6) @(negedge clk);
        spi_cs = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 20);
        check(tag, 32'(n <= 3), 32'd1);
        repeat (6) @(negedge clk);
    endtask

    // Expected effect of a complete frame from the register-array view
    task automatic predict(input logic rw, input logic ms, input logic [5:0] addr, input int nbytes);
        logic [5:0] a;
        exp_rd.delete();
        exp_wr.delete();
        got_wr.delete();
        for (int j = 0; j < (ms ? nbytes : 1); j++) begin
            a = addr + 6'(j);
            if (rw) exp_rd.push_back(model[a]);
            else if (a != ID_A) begin
                model[a] = wq[j];
                exp_wr.push_back({a, wq[j]});
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic rw);
        check({tag, "_oe"}, 32'(oe_err), 32'd0);
        if (rw) begin
            check({tag, "_nrd"}, 32'(rq.size()), 32'(exp_rd.size()));
            for (int j = 0; j < exp_rd.size() && j < rq.size(); j++)
                check({tag, "_rd"}, 32'(rq[j]), 32'(exp_rd[j]));
        end
        check({tag, "_nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int j = 0; j < exp_wr.size() && j < got_wr.size(); j++)
            check({tag, "_wr"}, 32'(got_wr[j]), 32'(exp_wr[j]));
    endtask

    task automatic check_host(input string tag, input logic [5:0] a);
        host_addr = a;
        @(negedge clk);
        check(tag, 32'(host_rdata), 32'(model[a]));
    endtask

    initial begin
        logic       rw, ms, s;
        logic [5:0] addr;
        int         n;

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(miso_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_waddr", 32'(wr_addr), 32'd0);
        check("rst_wdata", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_host("rst_id", ID_A);
        check_host("rst_r5", 6'd5);

        // Single write
        wq.delete(); wq.push_back(8'hA5);
        predict(1'b0, 1'b0, 6'd5, 1);
        frame(1'b0, 1'b0, 6'd5, 1, -1);
        wait_idle("wr1_busy");
        check_frame("wr1", 1'b0);
        check_host("wr1_host", 6'd5);
        check("wr1_const", 32'(host_rdata), 32'h0A5);

        // Single read, then identity read
        predict(1'b1, 1'b0, 6'd5, 1);
        frame(1'b1, 1'b0, 6'd5, 1, -1);
        wait_idle("rd1_busy");
        check_frame("rd1", 1'b1);
        check("rd1_const", 32'(rq.size() > 0 ? rq[0] : 8'h00), 32'h0A5);
        predict(1'b1, 1'b0, ID_A, 1);
        frame(1'b1, 1'b0, ID_A, 1, -1);
        wait_idle("rdid_busy");
        check_frame("rdid", 1'b1);

        // Burst write wrapping 62 -> 63 -> 0
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33);
        predict(1'b0, 1'b1, 6'd62, 3);
        frame(1'b0, 1'b1, 6'd62, 3, -1);
        wait_idle("bw_busy");
        check_frame("bw", 1'b0);
        check_host("bw_62", 6'd62);
        check_host("bw_63", 6'd63);
        check_host("bw_0", 6'd0);

        // Burst read back across the wrap
        predict(1'b1, 1'b1, 6'd62, 3);
        frame(1'b1, 1'b1, 6'd62, 3, -1);
        wait_idle("br_busy");
        check_frame("br", 1'b1);

        // Write to the identity register is dropped
        wq.delete(); wq.push_back(8'hFF);
        predict(1'b0, 1'b0, ID_A, 1);
        frame(1'b0, 1'b0, ID_A, 1, -1);
        wait_idle("idw_busy");
        check_frame("idw", 1'b0);
        predict(1'b1, 1'b0, ID_A, 1);
        frame(1'b1, 1'b0, ID_A, 1, -1);
        wait_idle("idr_busy");
        check_frame("idr", 1'b1);

        // Abort after 4 data bits, then clocks with cs high must be ignored
        wq.delete(); wq.push_back(8'hFF);
        got_wr.delete();
        frame(1'b0, 1'b0, 6'd7, 1, 4);
        wait_idle("abort_busy");
        spi_mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            spi_clk = ~spi_clk;
            repeat (6) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        check("abort_nwr", 32'(got_wr.size()), 32'd0);
        check_host("abort_r7", 6'd7);

        // Reset during the read data phase
        spi_cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] c;
            c = {2'b10, 6'd5};
            clock_bit(c[7-i], 1'b0, 1'b1, s);
        end
        for (int k = 0; k < 3; k++) clock_bit(1'b0, 1'b1, 1'b1, s);
        check("mid_oe", 32'(miso_oe), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_oe", 32'(miso_oe), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_miso", 32'(spi_miso), 32'd0);
        spi_cs = 1'b1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        model_reset();
        check_host("mrst_r5", 6'd5);
        check_host("mrst_id", ID_A);

        // Randomized frames
        for (int f = 0; f < 20; f++) begin
            rw   = 1'($urandom_range(0, 1));
            ms   = 1'($urandom_range(0, 1));
            addr = 6'($urandom_range(0, 63));
            if (f % 5 == 0) addr = ID_A;
            n    = ms ? int'($urandom_range(1, 4)) : 1;
            wq.delete();
            for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
            predict(rw, ms, addr, n);
            frame(rw, ms, addr, n, -1);
            wait_idle("rnd_busy");
            check_frame("rnd", rw);
            check_host("rnd_host", addr);
            check_host("rnd_hostx", 6'($urandom_range(0, 63)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
